// File: rtl/nes_mem_pkg.sv
// rtl/nes_mem_pkg.sv - shared types and constants for the cartridge memory arbiter
package nes_mem_pkg;

  localparam int         ADDR_W_DEF    = 22;
  localparam logic [7:0] RDATA_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {IDLE, ARB, BUSY, DONE} arb_state_t;

  typedef enum logic [1:0] {REQ_LDR, REQ_CHR, REQ_PRG} req_id_t;

  typedef struct packed {
    logic                  pending;
    logic [ADDR_W_DEF-1:0] addr;
    logic                  we;
    logic [7:0]            wdata;
    logic                  allow;
  } mem_slot_t;

endpackage

// File: rtl/nes_mem_slot.sv
// rtl/nes_mem_slot.sv - one requester slot: strobe capture, overrun detect, pending clear
module nes_mem_slot
  import nes_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [7:0]        i_wdata,
  input  logic              i_allow,
  input  logic              i_clear,
  output mem_slot_t         o_slot,
  output logic              o_overrun
);

  mem_slot_t r_slot;
  logic      w_accept;

  // A strobe landing on the clearing cycle is taken as the next request.
  assign w_accept  = i_req && (!r_slot.pending || i_clear);
  assign o_overrun = i_req && !w_accept;
  assign o_slot    = r_slot;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot <= '0;
    end else if (w_accept) begin
      r_slot.pending <= 1'b1;
      r_slot.addr    <= ADDR_W_DEF'(i_addr);
      r_slot.we      <= i_we;
      r_slot.wdata   <= i_wdata;
      r_slot.allow   <= i_allow;
    end else if (i_clear) begin
      r_slot.pending <= 1'b0;
    end
  end

endmodule

// File: rtl/nes_mem_arbiter.sv
// rtl/nes_mem_arbiter.sv - sequences CHR, PRG and loader accesses onto one memory port
module nes_mem_arbiter
  import nes_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int TIMEOUT      = 15,
  parameter int PRG_MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chr_req,
  input  logic [ADDR_W-1:0] chr_addr,
  input  logic              chr_we,
  input  logic [7:0]        chr_wdata,
  input  logic              chr_allow,
  output logic              chr_ack,
  output logic [7:0]        chr_rdata,
  input  logic              prg_req,
  input  logic [ADDR_W-1:0] prg_addr,
  input  logic              prg_we,
  input  logic [7:0]        prg_wdata,
  input  logic              prg_allow,
  output logic              prg_ack,
  output logic [7:0]        prg_rdata,
  input  logic              ldr_req,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_wdata,
  output logic              ldr_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [3:0]        status
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  arb_state_t        r_state, w_next;
  req_id_t           r_win, w_win;
  mem_slot_t         w_ldr, w_chr, w_prg, w_sel;
  logic              w_ldr_ov, w_chr_ov, w_prg_ov;
  logic              w_clr_ldr, w_clr_chr, w_clr_prg;
  logic              w_any, w_filtered, w_issue, w_mem_done, w_tmo_hit, w_finish;
  logic [TMO_W-1:0]  r_tmo;
  logic [1:0]        r_prg_wait;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_chr_ack, r_prg_ack, r_ldr_ack;
  logic [7:0]        r_chr_rdata, r_prg_rdata;
  logic [3:0]        r_status;

  assign w_clr_ldr = (r_state == DONE) && (r_win == REQ_LDR);
  assign w_clr_chr = (r_state == DONE) && (r_win == REQ_CHR);
  assign w_clr_prg = (r_state == DONE) && (r_win == REQ_PRG);

  nes_mem_slot #(.ADDR_W(ADDR_W)) u_ldr_slot (
    .clk(clk), .reset(reset), .i_req(ldr_req), .i_addr(ldr_addr), .i_we(1'b1),
    .i_wdata(ldr_wdata), .i_allow(1'b1), .i_clear(w_clr_ldr),
    .o_slot(w_ldr), .o_overrun(w_ldr_ov)
  );

  nes_mem_slot #(.ADDR_W(ADDR_W)) u_chr_slot (
    .clk(clk), .reset(reset), .i_req(chr_req), .i_addr(chr_addr), .i_we(chr_we),
    .i_wdata(chr_wdata), .i_allow(chr_allow), .i_clear(w_clr_chr),
    .o_slot(w_chr), .o_overrun(w_chr_ov)
  );

  nes_mem_slot #(.ADDR_W(ADDR_W)) u_prg_slot (
    .clk(clk), .reset(reset), .i_req(prg_req), .i_addr(prg_addr), .i_we(prg_we),
    .i_wdata(prg_wdata), .i_allow(prg_allow), .i_clear(w_clr_prg),
    .o_slot(w_prg), .o_overrun(w_prg_ov)
  );

  // Falls back to CHR when nothing wins, so w_sel.pending doubles as "anything pending".
  always_comb begin
    w_win = REQ_CHR;
    w_sel = w_chr;
    if (w_ldr.pending) begin
      w_win = REQ_LDR;
      w_sel = w_ldr;
    end else if (w_prg.pending && (!w_chr.pending || r_prg_wait == 2'(PRG_MAX_WAIT))) begin
      w_win = REQ_PRG;
      w_sel = w_prg;
    end
    w_any      = w_sel.pending;
    w_filtered = w_sel.we && !w_sel.allow;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ARB;
      ARB:     w_next = w_filtered ? DONE : BUSY;
      BUSY:    if (mem_ack || w_tmo_hit) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_issue    = (r_state == ARB) && !w_filtered;
    w_mem_done = (r_state == BUSY) && mem_ack;
    w_tmo_hit  = (r_state == BUSY) && !mem_ack && (r_tmo == TMO_W'(TIMEOUT - 1));
    w_finish   = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win       <= REQ_LDR;
      r_tmo       <= '0;
      r_prg_wait  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_chr_ack   <= 1'b0;
      r_prg_ack   <= 1'b0;
      r_ldr_ack   <= 1'b0;
      r_chr_rdata <= RDATA_DEFAULT;
      r_prg_rdata <= RDATA_DEFAULT;
      r_status    <= '0;
    end else begin
      if (r_state == ARB) begin
        r_win <= w_win;
        r_tmo <= '0;
      end else if (r_state == BUSY && r_tmo != TMO_W'(TIMEOUT)) begin
        r_tmo <= r_tmo + 1'b1;
      end

      if (!w_prg.pending) begin
        r_prg_wait <= '0;
      end else if (r_state == ARB) begin
        if (w_win == REQ_PRG)
          r_prg_wait <= '0;
        else if (w_win == REQ_CHR && r_prg_wait != 2'b11)
          r_prg_wait <= r_prg_wait + 2'd1;
      end

      if (w_issue) begin
        r_mem_req   <= 1'b1;
        r_mem_addr  <= ADDR_W'(w_sel.addr);
        r_mem_we    <= w_sel.we;
        r_mem_wdata <= w_sel.wdata;
      end else if (w_mem_done || w_tmo_hit) begin
        r_mem_req <= 1'b0;
      end

      // A timed-out read returns the idle-bus value instead of stale data.
      if ((w_mem_done || w_tmo_hit) && !r_mem_we) begin
        if (r_win == REQ_CHR) r_chr_rdata <= w_mem_done ? mem_rdata : RDATA_DEFAULT;
        if (r_win == REQ_PRG) r_prg_rdata <= w_mem_done ? mem_rdata : RDATA_DEFAULT;
      end

      r_chr_ack <= w_finish && (r_win == REQ_CHR);
      r_prg_ack <= w_finish && (r_win == REQ_PRG);
      r_ldr_ack <= w_finish && (r_win == REQ_LDR);
      r_status  <= r_status | {w_tmo_hit, w_ldr_ov, w_prg_ov, w_chr_ov};
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign chr_ack   = r_chr_ack;
  assign prg_ack   = r_prg_ack;
  assign ldr_ack   = r_ldr_ack;
  assign chr_rdata = r_chr_rdata;
  assign prg_rdata = r_prg_rdata;
  assign status    = r_status;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// tb/tb_nes_mem_arbiter.sv - directed self-checking bench for nes_mem_arbiter
module tb_nes_mem_arbiter;

  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic          chr_req, chr_we, chr_allow, chr_ack;
  logic [AW-1:0] chr_addr;
  logic [7:0]    chr_wdata, chr_rdata;
  logic          prg_req, prg_we, prg_allow, prg_ack;
  logic [AW-1:0] prg_addr;
  logic [7:0]    prg_wdata, prg_rdata;
  logic          ldr_req, ldr_ack;
  logic [AW-1:0] ldr_addr;
  logic [7:0]    ldr_wdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_rdata = 8'hEE;
  logic [3:0]    status;

  logic          mem_en = 1'b1;
  logic          prev_req = 1'b0;
  int            req_cycles = 0;
  logic [AW-1:0] g_addr[$];
  logic          g_we[$];
  logic [7:0]    g_wdata[$];
  int            n_cmp = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  nes_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .chr_req(chr_req), .chr_addr(chr_addr), .chr_we(chr_we), .chr_wdata(chr_wdata),
    .chr_allow(chr_allow), .chr_ack(chr_ack), .chr_rdata(chr_rdata),
    .prg_req(prg_req), .prg_addr(prg_addr), .prg_we(prg_we), .prg_wdata(prg_wdata),
    .prg_allow(prg_allow), .prg_ack(prg_ack), .prg_rdata(prg_rdata),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .status(status)
  );

  // Memory answers during the first cycle it sees mem_req; read data = addr[7:0] ^ 8'h82.
  always @(negedge clk) begin
    if (mem_en && mem_req && !mem_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_addr[7:0] ^ 8'h82;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 8'hEE;
    end
    if (mem_req) req_cycles++;
    if (mem_req && !prev_req) begin
      g_addr.push_back(mem_addr);
      g_we.push_back(mem_we);
      g_wdata.push_back(mem_wdata);
    end
    prev_req = mem_req;
  end

  function automatic logic [AW-1:0] gaddr(input int k);
    if (k < g_addr.size()) return g_addr[k];
    return '1;
  endfunction

  task automatic put_chr(input logic [AW-1:0] a, input logic we, input logic [7:0] wd, input logic al);
    chr_req = 1'b1; chr_addr = a; chr_we = we; chr_wdata = wd; chr_allow = al;
  endtask

  task automatic put_prg(input logic [AW-1:0] a, input logic we, input logic [7:0] wd, input logic al);
    prg_req = 1'b1; prg_addr = a; prg_we = we; prg_wdata = wd; prg_allow = al;
  endtask

  task automatic put_ldr(input logic [AW-1:0] a, input logic [7:0] wd);
    ldr_req = 1'b1; ldr_addr = a; ldr_wdata = wd;
  endtask

  task automatic release_reqs();
    @(negedge clk);
    chr_req = 1'b0; prg_req = 1'b0; ldr_req = 1'b0;
  endtask

  task automatic wait_ack(input int which, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((which == 0 && ldr_ack) || (which == 1 && chr_ack) || (which == 2 && prg_ack)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    chr_req = 0; chr_addr = '0; chr_we = 0; chr_wdata = '0; chr_allow = 0;
    prg_req = 0; prg_addr = '0; prg_we = 0; prg_wdata = '0; prg_allow = 0;
    ldr_req = 0; ldr_addr = '0; ldr_wdata = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({ldr_ack, chr_ack, prg_ack} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b expected 000", {ldr_ack, chr_ack, prg_ack}); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    n_cmp++; if (status !== 4'h0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", status); end
    n_cmp++; if (chr_rdata !== 8'hFF) begin n_fail++; $display("FAIL reset_chr_rdata: got %h expected ff", chr_rdata); end
    n_cmp++; if (prg_rdata !== 8'hFF) begin n_fail++; $display("FAIL reset_prg_rdata: got %h expected ff", prg_rdata); end
    n_cmp++; if ({mem_addr, mem_wdata} !== '0) begin n_fail++; $display("FAIL reset_mem_fields: got %h/%h expected 0/0", mem_addr, mem_wdata); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_chr_read();
    int c, base;
    base = g_addr.size();
    put_chr(22'h20_1FD8, 1'b0, 8'h00, 1'b0);
    release_reqs();
    wait_ack(1, 12, c);
    n_cmp++; if (c !== 4) begin n_fail++; $display("FAIL chr_read_latency: got %0d expected 4", c); end
    n_cmp++; if (chr_rdata !== 8'h5A) begin n_fail++; $display("FAIL chr_read_data: got %h expected 5a", chr_rdata); end
    n_cmp++; if (gaddr(base) !== 22'h20_1FD8) begin n_fail++; $display("FAIL chr_read_addr: got %h expected 201fd8", gaddr(base)); end
    @(negedge clk);
    n_cmp++; if (chr_ack !== 1'b0) begin n_fail++; $display("FAIL chr_ack_width: got %b expected 0", chr_ack); end
  endtask

  task automatic test_filtered_write();
    int c, base, rc;
    base = g_addr.size();
    rc   = req_cycles;
    put_prg(22'h00_8000, 1'b1, 8'h77, 1'b0);
    release_reqs();
    wait_ack(2, 12, c);
    n_cmp++; if (c !== 3) begin n_fail++; $display("FAIL filt_latency: got %0d expected 3", c); end
    n_cmp++; if (req_cycles - rc !== 0) begin n_fail++; $display("FAIL filt_mem_req: got %0d req cycles expected 0", req_cycles - rc); end
    n_cmp++; if (g_addr.size() - base !== 0) begin n_fail++; $display("FAIL filt_grants: got %0d expected 0", g_addr.size() - base); end
    n_cmp++; if (prg_rdata !== 8'hFF) begin n_fail++; $display("FAIL filt_rdata: got %h expected ff", prg_rdata); end
  endtask

  task automatic test_ldr_priority();
    int cl, cc, base;
    base = g_addr.size();
    cl = -1; cc = -1;
    put_chr(22'h00_1234, 1'b0, 8'h00, 1'b1);
    put_ldr(22'h3C_0000, 8'hA5);
    release_reqs();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ldr_ack) cl = i;
      if (chr_ack) cc = i;
    end
    n_cmp++; if (cl !== 4) begin n_fail++; $display("FAIL ldr_ack_cycle: got %0d expected 4", cl); end
    n_cmp++; if (cc !== 8) begin n_fail++; $display("FAIL ldr_then_chr_cycle: got %0d expected 8", cc); end
    n_cmp++; if (gaddr(base) !== 22'h3C_0000) begin n_fail++; $display("FAIL ldr_first_addr: got %h expected 3c0000", gaddr(base)); end
    n_cmp++; if (g_addr.size() < base + 1 || g_we[base] !== 1'b1 || g_wdata[base] !== 8'hA5) begin
      n_fail++; $display("FAIL ldr_write_fields: grants %0d expected we=1 wdata=a5", g_addr.size() - base);
    end
    n_cmp++; if (gaddr(base + 1) !== 22'h00_1234) begin n_fail++; $display("FAIL ldr_second_addr: got %h expected 001234", gaddr(base + 1)); end
    n_cmp++; if (chr_rdata !== 8'hB6) begin n_fail++; $display("FAIL ldr_chr_rdata: got %h expected b6", chr_rdata); end
  endtask

  task automatic test_arb_same_cycle();
    int cc, cp, base;
    base = g_addr.size();
    cc = -1; cp = -1;
    put_chr(22'h00_0111, 1'b0, 8'h00, 1'b1);
    put_prg(22'h00_C0F0, 1'b0, 8'h00, 1'b1);
    release_reqs();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (chr_ack) cc = i;
      if (prg_ack) cp = i;
    end
    n_cmp++; if (gaddr(base) !== 22'h00_0111) begin n_fail++; $display("FAIL same_first_chr: got %h expected 000111", gaddr(base)); end
    n_cmp++; if (gaddr(base + 1) !== 22'h00_C0F0) begin n_fail++; $display("FAIL same_second_prg: got %h expected 00c0f0", gaddr(base + 1)); end
    n_cmp++; if (cc !== 4 || cp !== 8) begin n_fail++; $display("FAIL same_ack_cycles: got %0d/%0d expected 4/8", cc, cp); end
    n_cmp++; if ({chr_rdata, prg_rdata} !== 16'h9372) begin n_fail++; $display("FAIL same_rdata: got %h/%h expected 93/72", chr_rdata, prg_rdata); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic prg_seen;
    logic [AW-1:0] nxt;
    base = g_addr.size();
    prg_seen = 1'b0;
    nxt = 22'h10_0001;
    put_chr(22'h10_0000, 1'b0, 8'h00, 1'b1);
    put_prg(22'h00_C001, 1'b0, 8'h00, 1'b1);
    release_reqs();
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      chr_req = 1'b0;
      if (prg_ack) prg_seen = 1'b1;
      if (chr_ack && !prg_seen) begin
        put_chr(nxt, 1'b0, 8'h00, 1'b1);
        nxt = nxt + 1'b1;
      end
    end
    n_cmp++; if (prg_seen !== 1'b1) begin n_fail++; $display("FAIL starve_prg_ack: got %b expected 1", prg_seen); end
    n_cmp++; if (g_addr.size() - base !== 5) begin n_fail++; $display("FAIL starve_grants: got %0d expected 5", g_addr.size() - base); end
    n_cmp++; if (gaddr(base + 2) !== 22'h10_0002) begin n_fail++; $display("FAIL starve_third_chr: got %h expected 100002", gaddr(base + 2)); end
    n_cmp++; if (gaddr(base + 3) !== 22'h00_C001) begin n_fail++; $display("FAIL starve_prg_promoted: got %h expected 00c001", gaddr(base + 3)); end
    n_cmp++; if (gaddr(base + 4) !== 22'h10_0003) begin n_fail++; $display("FAIL starve_last_chr: got %h expected 100003", gaddr(base + 4)); end
    n_cmp++; if (prg_rdata !== 8'h83) begin n_fail++; $display("FAIL starve_prg_rdata: got %h expected 83", prg_rdata); end
  endtask

  task automatic test_timeout();
    int c, rc;
    mem_en = 1'b0;
    rc = req_cycles;
    put_prg(22'h00_9000, 1'b0, 8'h00, 1'b1);
    release_reqs();
    wait_ack(2, 40, c);
    n_cmp++; if (c !== 18) begin n_fail++; $display("FAIL tmo_latency: got %0d expected 18", c); end
    n_cmp++; if (req_cycles - rc !== 15) begin n_fail++; $display("FAIL tmo_busy_cycles: got %0d expected 15", req_cycles - rc); end
    n_cmp++; if (prg_rdata !== 8'hFF) begin n_fail++; $display("FAIL tmo_rdata: got %h expected ff", prg_rdata); end
    n_cmp++; if (status !== 4'b1000) begin n_fail++; $display("FAIL tmo_status: got %b expected 1000", status); end
    mem_en = 1'b1;
    put_prg(22'h00_9055, 1'b0, 8'h00, 1'b1);
    release_reqs();
    wait_ack(2, 12, c);
    n_cmp++; if (c !== 4 || prg_rdata !== 8'hD7) begin n_fail++; $display("FAIL tmo_recover: got %0d/%h expected 4/d7", c, prg_rdata); end
  endtask

  task automatic test_overrun();
    int c, base;
    base = g_addr.size();
    put_chr(22'h00_0AAA, 1'b0, 8'h00, 1'b1);
    release_reqs();
    put_chr(22'h00_0BBB, 1'b0, 8'h00, 1'b1);
    release_reqs();
    wait_ack(1, 12, c);
    repeat (6) @(negedge clk);
    n_cmp++; if (c !== 3) begin n_fail++; $display("FAIL ovr_ack: got %0d expected 3", c); end
    n_cmp++; if (status !== 4'b1001) begin n_fail++; $display("FAIL ovr_status: got %b expected 1001", status); end
    n_cmp++; if (gaddr(base) !== 22'h00_0AAA || g_addr.size() - base !== 1) begin
      n_fail++; $display("FAIL ovr_first_kept: got %h (%0d grants) expected 000aaa (1)", gaddr(base), g_addr.size() - base);
    end
    n_cmp++; if (chr_rdata !== 8'h28) begin n_fail++; $display("FAIL ovr_rdata: got %h expected 28", chr_rdata); end
  endtask

  task automatic test_reset_busy();
    int acks, c;
    logic seen;
    acks = 0;
    seen = 1'b0;
    mem_en = 1'b0;
    put_prg(22'h00_9100, 1'b0, 8'h00, 1'b1);
    release_reqs();
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstb_busy_reached: got %b expected 1", seen); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstb_mem_req: got %b expected 0", mem_req); end
    n_cmp++; if (status !== 4'h0) begin n_fail++; $display("FAIL rstb_status: got %h expected 0", status); end
    reset  = 1'b0;
    mem_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (chr_ack || prg_ack || ldr_ack) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rstb_no_ack: got %0d expected 0", acks); end
    put_chr(22'h00_0005, 1'b0, 8'h00, 1'b1);
    release_reqs();
    wait_ack(1, 12, c);
    n_cmp++; if (c !== 4 || chr_rdata !== 8'h87) begin n_fail++; $display("FAIL rstb_after: got %0d/%h expected 4/87", c, chr_rdata); end
  endtask

  initial begin
    test_reset();
    test_chr_read();
    test_filtered_write();
    test_ldr_priority();
    test_arb_same_cycle();
    test_back_to_back();
    test_timeout();
    test_overrun();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
